mem_arbiter: RTL

Arbitrates the single byte-serial RAM controller between instruction fetch (IF) and the load/store buffer (LSB). Grants one requester at a time and latches its request into the controller's inst or data port. Returns the result with a one-cycle ack. Drops in-flight fetches on pipeline flush.

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbiter between instruction fetch and the load/store buffer for a single
// byte-serial memory controller; latches the granted request onto the controller ports.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,

  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_ack_out,
  output logic [DATA_W-1:0] if_inst_out,

  input  logic              ls_req_in,
  input  logic              ls_rw_in,
  input  logic              ls_sgn_in,
  input  logic [2:0]        ls_width_in,
  input  logic [ADDR_W-1:0] ls_addr_in,
  input  logic [DATA_W-1:0] ls_wdata_in,
  output logic              ls_ack_out,
  output logic [DATA_W-1:0] ls_rdata_out,

  output logic              mc_inst_en_out,
  output logic [ADDR_W-1:0] mc_inst_addr_out,
  input  logic              mc_inst_rdy_in,
  input  logic [DATA_W-1:0] mc_inst_in,

  output logic              mc_data_en_out,
  output logic              mc_data_rw_out,
  output logic              mc_data_sgn_out,
  output logic [2:0]        mc_data_width_out,
  output logic [ADDR_W-1:0] mc_data_addr_out,
  output logic [DATA_W-1:0] mc_data_wdata_out,
  input  logic              mc_data_rdy_in,
  input  logic [DATA_W-1:0] mc_data_in
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    INST_BUSY,
    DATA_BUSY,
    INST_DRAIN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             if_pend;
  logic             if_wins;

  // A flushed fetch is never pending; IF only beats a pending LSB once starved.
  always_comb begin
    if_pend = if_req_in && !flush_in;
    if_wins = if_pend && (!ls_req_in || (starve_cnt == CNT_MAX));
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state             <= IDLE;
      starve_cnt        <= '0;
      if_ack_out        <= 1'b0;
      if_inst_out       <= '0;
      ls_ack_out        <= 1'b0;
      ls_rdata_out      <= '0;
      mc_inst_en_out    <= 1'b0;
      mc_inst_addr_out  <= '0;
      mc_data_en_out    <= 1'b0;
      mc_data_rw_out    <= 1'b0;
      mc_data_sgn_out   <= 1'b0;
      mc_data_width_out <= '0;
      mc_data_addr_out  <= '0;
      mc_data_wdata_out <= '0;
    end else if (rdy_in) begin
      if_ack_out <= 1'b0;
      ls_ack_out <= 1'b0;
      case (state)
        IDLE: begin
          if (if_wins) begin
            mc_inst_addr_out <= if_addr_in;
            mc_inst_en_out   <= 1'b1;
            starve_cnt       <= '0;
            state            <= INST_BUSY;
          end else if (ls_req_in) begin
            mc_data_rw_out    <= ls_rw_in;
            mc_data_sgn_out   <= ls_sgn_in;
            mc_data_width_out <= ls_width_in;
            mc_data_addr_out  <= ls_addr_in;
            mc_data_wdata_out <= ls_wdata_in;
            mc_data_en_out    <= 1'b1;
            state             <= DATA_BUSY;
            if (!if_pend)
              starve_cnt <= '0;
            else if (starve_cnt != CNT_MAX)
              starve_cnt <= starve_cnt + 1'b1;
          end else begin
            starve_cnt <= '0;
          end
        end
        INST_BUSY: begin
          if (flush_in) begin
            // A flush coinciding with the done pulse needs no drain.
            if (mc_inst_rdy_in) begin
              mc_inst_en_out <= 1'b0;
              state          <= IDLE;
            end else begin
              state <= INST_DRAIN;
            end
          end else if (mc_inst_rdy_in) begin
            if_inst_out    <= mc_inst_in;
            if_ack_out     <= 1'b1;
            mc_inst_en_out <= 1'b0;
            state          <= IDLE;
          end
        end
        INST_DRAIN: begin
          if (mc_inst_rdy_in) begin
            mc_inst_en_out <= 1'b0;
            state          <= IDLE;
          end
        end
        DATA_BUSY: begin
          if (mc_data_rdy_in) begin
            if (mc_data_rw_out)
              ls_rdata_out <= mc_data_in;
            ls_ack_out     <= 1'b1;
            mc_data_en_out <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
